counter_timer_ctrl: RTL and testbench
=====================================

// Module: counter_timer_ctrl
// PURPOSE
//  Sequencer for one loadable up-counter (clk/rst/cen/wen/dat, posedge output o_p).
//  Accepts timer commands over a valid/ready port and drives the counter's cen/wen/dat.
//  Compares the counter value to a terminal value and reports one-shot or periodic expiry.
//  Sits between a register/CPU front end and the counter instance. Both share clk and rst.
// PARAMETERS
//  WIDTH  8  counter width; width of cmd_load, cmd_term, cnt_dat, cnt_val
//  PRE_W  4  prescaler width; counter advances once every (cmd_pre+1) cycles
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rst        in   1      reset, synchronous, active-high
//  cmd_valid  in   1      command valid
//  cmd_ready  out  1      command ready
//  cmd_op     in   2      00 NOP, 01 START_ONESHOT, 10 START_PERIODIC, 11 STOP
//  cmd_load   in   WIDTH  start value written into the counter
//  cmd_term   in   WIDTH  terminal value
//  cmd_pre    in   PRE_W  prescale divisor minus 1
//  cnt_cen    out  1      to counter cen
//  cnt_wen    out  1      to counter wen
//  cnt_dat    out  WIDTH  to counter dat
//  cnt_val    in   WIDTH  from counter o_p (posedge value)
//  busy       out  1      high when state != IDLE
//  tick       out  1      1-cycle pulse on terminal count
//  done       out  1      1-cycle pulse when a one-shot completes
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge):
//    - state=IDLE; config regs and prescale count pc cleared.
//    - While rst=1, every output is 0, including cmd_ready.
//  - States: IDLE, LOAD, RUN.
//  - A command is accepted when cmd_valid && cmd_ready.
//  - cmd_ready = !rst && state!=LOAD.
//  - NOP is accepted and has no effect.
//  - START (IDLE or RUN):
//    - Latch load/term/pre/mode; pc=0; next state LOAD.
//    - In RUN, START restarts with the new config.
//  - LOAD (exactly 1 cycle): cnt_wen=1, cnt_dat=load_r, cnt_cen=0; next state RUN.
//  - RUN, non-terminal (cnt_val!=term_r):
//    - If pc==pre_r: cnt_cen=1 and pc=0. Else pc=pc+1.
//  - RUN, terminal (cnt_val==term_r):
//    - cnt_cen=0 and tick=1.
//    - One-shot: done=1, next state IDLE.
//    - Periodic: pc=0, next state LOAD (reload).
//  - Timing:
//    - First RUN cycle sees cnt_val=load.
//    - Terminal occurs (D*(pre+1))+1 cycles after the LOAD cycle, with D=(term-load) mod 2^WIDTH.
//    - term<load wraps through 0. load==term gives tick in the first RUN cycle.
//    - Periodic tick period = D*(pre+1)+2 cycles.
//  - STOP:
//    - In RUN: next state IDLE; cnt_cen=0 that cycle.
//    - In IDLE: no effect.
//  - Simultaneous events: an accepted STOP or START in a terminal cycle wins; tick and done are suppressed that cycle.
//  - Outputs:
//    - cnt_wen, cnt_dat and busy are decoded from state.
//    - cnt_cen, tick and done are combinational from state, pc, cnt_val and the accepted command.
//    - cnt_dat=0 outside LOAD.
//  - Reset mid-operation: IDLE on the next cycle, no tick/done. The counter is cleared by the same rst.
// STRUCTURE
//  - counter_ctrl_pkg: state encoding (IDLE/LOAD/RUN) and the cmd_op opcode constants.
//  - Sub-module counter_prescaler:
//    - Contains pc, a clear input and a (pc==pre_r) strobe.
//    - Its strobe is qualified by RUN && !terminal.
//  - Bench instantiates counter #(WIDTH) with cen/wen/dat/o_p wired to cnt_* and cnt_val.
// TESTING
//  1. Reset, then START_ONESHOT load=3 term=7 pre=0:
//     LOAD 1 cycle (wen, dat=3); cen for 4 cycles; tick+done once; busy low after.
//  2. START_PERIODIC load=0 term=2 pre=1:
//     tick every 6 cycles for 4 periods; wen once per period.
//  3. Wrap: START_ONESHOT load=8'hFE term=8'h01 pre=0:
//     3 cen pulses, tick when cnt_val=1.
//  4. STOP in RUN at cnt_val=5 (term=9):
//     IDLE next cycle, no tick/done, counter holds 5.
//     STOP issued in the terminal cycle: tick suppressed.
//  5. rst asserted mid-RUN for 1 cycle:
//     all outputs 0 during reset, IDLE after, cmd_ready=1, no done.
//     START in RUN: immediate reload with the new load value.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state encoding and command opcodes for the timer sequencer
package counter_ctrl_pkg;

    // Sequencer states: IDLE waits for a command, LOAD writes the start value, RUN counts.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } ctrl_state_e;

    // cmd_op encodings.
    localparam logic [1:0] OP_NOP            = 2'b00;
    localparam logic [1:0] OP_START_ONESHOT  = 2'b01;
    localparam logic [1:0] OP_START_PERIODIC = 2'b10;
    localparam logic [1:0] OP_STOP           = 2'b11;

    // True for either flavour of START.
    function automatic logic is_start(input logic [1:0] op);
        return (op == OP_START_ONESHOT) || (op == OP_START_PERIODIC);
    endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - loadable up-counter driven by the timer sequencer
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             wen,
    input  logic [WIDTH-1:0] dat,
    output logic [WIDTH-1:0] o_p
);

    logic [WIDTH-1:0] cnt_q;

    assign o_p = cnt_q;

    // Load has priority over count enable; value holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wen) begin
            cnt_q <= dat;
        end else if (cen) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - prescale counter that strobes once every (pre+1) advances
module counter_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             adv_i,
    input  logic [PRE_W-1:0] pre_i,
    output logic             strobe_o
);

    logic [PRE_W-1:0] pc_q;
    logic [PRE_W-1:0] pc_d;

    // Strobe marks the last cycle of a prescale period; the owner decides whether it counts.
    assign strobe_o = (pc_q == pre_i);

    // Next prescale count: clear wins, otherwise wrap on strobe or step by one.
    always_comb begin
        pc_d = pc_q;
        if (clear_i) begin
            pc_d = '0;
        end else if (adv_i) begin
            pc_d = strobe_o ? '0 : pc_q + 1'b1;
        end
    end

    // Prescale count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/counter_timer_ctrl.sv
// rtl/counter_timer_ctrl.sv - command-driven sequencer for one loadable up-counter
module counter_timer_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_load,
    input  logic [WIDTH-1:0] cmd_term,
    input  logic [PRE_W-1:0] cmd_pre,
    output logic             cnt_cen,
    output logic             cnt_wen,
    output logic [WIDTH-1:0] cnt_dat,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    ctrl_state_e      state_q;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] term_q;
    logic [PRE_W-1:0] pre_q;
    logic             periodic_q;

    logic in_load;
    logic in_run;
    logic cmd_acc;
    logic start_acc;
    logic stop_acc;
    logic cmd_override;
    logic terminal;
    logic run_step;
    logic pre_strobe;

    assign in_load = (state_q == ST_LOAD);
    assign in_run  = (state_q == ST_RUN);

    // LOAD is a fixed single cycle, so commands are held off only there.
    assign cmd_ready = !rst && !in_load;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign start_acc = cmd_acc && is_start(cmd_op);
    // STOP only matters while running; in IDLE it is accepted and ignored.
    assign stop_acc  = cmd_acc && (cmd_op == OP_STOP) && in_run;

    // A START or STOP landing on the terminal cycle takes precedence over expiry.
    assign cmd_override = start_acc || stop_acc;
    assign terminal     = in_run && (cnt_val == term_q);
    assign run_step     = !rst && in_run && !terminal && !cmd_override;

    assign cnt_cen = run_step && pre_strobe;
    assign cnt_wen = !rst && in_load;
    assign cnt_dat = cnt_wen ? load_q : '0;
    assign busy    = !rst && (state_q != ST_IDLE);
    assign tick    = !rst && terminal && !cmd_override;
    assign done    = tick && !periodic_q;

    // Prescale restarts on every START and on every expiry so each period begins aligned.
    counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (start_acc || terminal),
        .adv_i    (run_step),
        .pre_i    (pre_q),
        .strobe_o (pre_strobe)
    );

    // Sequencer FSM and latched configuration; START restarts from any accepting state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            load_q     <= '0;
            term_q     <= '0;
            pre_q      <= '0;
            periodic_q <= 1'b0;
        end else if (start_acc) begin
            load_q     <= cmd_load;
            term_q     <= cmd_term;
            pre_q      <= cmd_pre;
            periodic_q <= (cmd_op == OP_START_PERIODIC);
            state_q    <= ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_IDLE;
                ST_LOAD: state_q <= ST_RUN;
                ST_RUN: begin
                    if (stop_acc) begin
                        state_q <= ST_IDLE;
                    end else if (terminal) begin
                        state_q <= periodic_q ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// tb/tb_counter_timer_ctrl.sv - self-checking bench for counter_timer_ctrl with its counter
module tb_counter_timer_ctrl;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_load;
    logic [WIDTH-1:0] cmd_term;
    logic [PRE_W-1:0] cmd_pre;
    logic             cnt_cen;
    logic             cnt_wen;
    logic [WIDTH-1:0] cnt_dat;
    logic [WIDTH-1:0] cnt_val;
    logic             busy;
    logic             tick;
    logic             done;

    always #5 clk = ~clk;

    counter_timer_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_load  (cmd_load),
        .cmd_term  (cmd_term),
        .cmd_pre   (cmd_pre),
        .cnt_cen   (cnt_cen),
        .cnt_wen   (cnt_wen),
        .cnt_dat   (cnt_dat),
        .cnt_val   (cnt_val),
        .busy      (busy),
        .tick      (tick),
        .done      (done)
    );

    counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .cen (cnt_cen),
        .wen (cnt_wen),
        .dat (cnt_dat),
        .o_p (cnt_val)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: timer either idle or k cycles past its LOAD cycle.
    bit       m_active = 1'b0;
    int       m_k      = 0;
    bit [7:0] m_load   = 8'd0;
    bit [7:0] m_term   = 8'd0;
    int       m_pre    = 0;
    bit       m_per    = 1'b0;
    bit [7:0] m_cnt    = 8'd0;

    // Observations taken from the DUT for the literal checks.
    int       o_cen, o_tick, o_done, o_wen, o_wen_cyc;
    int       o_tick_cyc[$];
    logic [7:0] o_tick_val, o_wen_dat;

    task automatic clear_obs();
        o_cen = 0; o_tick = 0; o_done = 0; o_wen = 0; o_wen_cyc = -1;
        o_tick_cyc.delete();
        o_tick_val = 8'd0; o_wen_dat = 8'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model, advance the model.
    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic [7:0] ld, input logic [7:0] tm, input logic [3:0] pr);
        bit       e_ready, e_cen, e_wen, e_busy, e_tick, e_done, term_f;
        bit       acc, st, sp;
        bit [7:0] e_dat, diff;
        int       j, p, d, t;
        rst = r; cmd_valid = v; cmd_op = op; cmd_load = ld; cmd_term = tm; cmd_pre = pr;
        @(negedge clk);
        e_ready = 0; e_cen = 0; e_wen = 0; e_busy = 0; e_tick = 0; e_done = 0;
        e_dat = 8'd0; term_f = 0; st = 0; sp = 0;
        if (!r) begin
            e_ready = !(m_active && m_k == 0);
            acc = v && e_ready;
            st  = acc && (op == 2'b01 || op == 2'b10);
            sp  = acc && (op == 2'b11) && m_active;
            if (m_active) begin
                e_busy = 1;
                if (m_k == 0) begin
                    e_wen = 1;
                    e_dat = m_load;
                end else begin
                    j      = m_k - 1;
                    p      = m_pre + 1;
                    diff   = m_term - m_load;
                    d      = int'(diff);
                    t      = d * p;
                    term_f = (j == t);
                    e_cen  = !term_f && !st && !sp && ((j % p) == p - 1);
                    e_tick = term_f && !st && !sp;
                    e_done = e_tick && !m_per;
                end
            end
        end
        chk("cmd_ready", cmd_ready, e_ready);
        chk("cnt_cen",   cnt_cen,   e_cen);
        chk("cnt_wen",   cnt_wen,   e_wen);
        chk("cnt_dat",   cnt_dat,   e_dat);
        chk("busy",      busy,      e_busy);
        chk("tick",      tick,      e_tick);
        chk("done",      done,      e_done);
        chk("cnt_val",   cnt_val,   m_cnt);
        if (cnt_cen === 1'b1) o_cen++;
        if (cnt_wen === 1'b1) begin o_wen++; o_wen_cyc = cyc; o_wen_dat = cnt_dat; end
        if (tick === 1'b1) begin o_tick++; o_tick_cyc.push_back(cyc); o_tick_val = cnt_val; end
        if (done === 1'b1) o_done++;
        if (r) begin
            m_active = 0;
            m_cnt    = 8'd0;
        end else begin
            if (e_wen) m_cnt = e_dat;
            else if (e_cen) m_cnt = m_cnt + 8'd1;
            if (st) begin
                m_load = ld; m_term = tm; m_pre = int'(pr); m_per = (op == 2'b10);
                m_active = 1; m_k = 0;
            end else if (m_active) begin
                if (m_k == 0) m_k = 1;
                else if (sp) m_active = 0;
                else if (term_f) begin
                    if (m_per) m_k = 0;
                    else m_active = 0;
                end else m_k++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 4'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd0);
        step(1'b1, 1'b1, 2'b01, 8'd5, 8'd9, 4'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_load = 8'd0; cmd_term = 8'd0; cmd_pre = 4'd0;
        @(posedge clk);
        #1;

        // 1: one-shot 3 -> 7, no prescale.
        do_reset();
        clear_obs();
        s = cyc;
        step(1'b0, 1'b1, 2'b01, 8'd3, 8'd7, 4'd0);
        idle(12);
        chk("t1_cen_pulses", o_cen, 4);
        chk("t1_ticks", o_tick, 1);
        chk("t1_dones", o_done, 1);
        chk("t1_wen_count", o_wen, 1);
        chk("t1_wen_dat", o_wen_dat, 8'd3);
        if (o_tick_cyc.size() > 0) chk("t1_tick_latency", o_tick_cyc[0] - s, 6);
        chk("t1_busy_after", busy, 1'b0);

        // 2: periodic 0 -> 2, prescale by 2: period of 6 cycles.
        do_reset();
        clear_obs();
        s = cyc;
        step(1'b0, 1'b1, 2'b10, 8'd0, 8'd2, 4'd1);
        idle(24);
        chk("t2_ticks", o_tick, 4);
        chk("t2_wen_count", o_wen, 4);
        chk("t2_cen_pulses", o_cen, 8);
        chk("t2_dones", o_done, 0);
        if (o_tick_cyc.size() == 4) begin
            chk("t2_first_tick", o_tick_cyc[0] - s, 6);
            for (int i = 1; i < 4; i++) chk("t2_tick_period", o_tick_cyc[i] - o_tick_cyc[i-1], 6);
        end

        // 3: wrap FE -> 01.
        do_reset();
        clear_obs();
        s = cyc;
        step(1'b0, 1'b1, 2'b01, 8'hFE, 8'h01, 4'd0);
        idle(8);
        chk("t3_cen_pulses", o_cen, 3);
        chk("t3_ticks", o_tick, 1);
        chk("t3_tick_val", o_tick_val, 8'h01);
        if (o_tick_cyc.size() > 0) chk("t3_tick_latency", o_tick_cyc[0] - s, 5);

        // 4a: STOP while counter shows 5.
        do_reset();
        clear_obs();
        step(1'b0, 1'b1, 2'b01, 8'd0, 8'd9, 4'd0);
        idle(6);
        chk("t4_val_at_stop", cnt_val, 8'd5);
        step(1'b0, 1'b1, 2'b11, 8'd0, 8'd0, 4'd0);
        idle(5);
        chk("t4_ticks", o_tick, 0);
        chk("t4_dones", o_done, 0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_hold", cnt_val, 8'd5);

        // 4b: STOP on the terminal cycle suppresses tick.
        do_reset();
        clear_obs();
        step(1'b0, 1'b1, 2'b01, 8'd0, 8'd2, 4'd0);
        idle(3);
        step(1'b0, 1'b1, 2'b11, 8'd0, 8'd0, 4'd0);
        idle(4);
        chk("t4b_ticks", o_tick, 0);
        chk("t4b_hold", cnt_val, 8'd2);

        // 5a: reset for one cycle mid-RUN.
        do_reset();
        step(1'b0, 1'b1, 2'b01, 8'd0, 8'd9, 4'd0);
        idle(4);
        clear_obs();
        step(1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 4'd0);
        idle(12);
        chk("t5_dones", o_done, 0);
        chk("t5_ready", cmd_ready, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_cnt", cnt_val, 8'd0);

        // 5b: START while running reloads immediately.
        step(1'b0, 1'b1, 2'b01, 8'd0, 8'd50, 4'd0);
        idle(5);
        clear_obs();
        s = cyc;
        step(1'b0, 1'b1, 2'b01, 8'd20, 8'd22, 4'd0);
        idle(6);
        chk("t5b_wen_cyc", o_wen_cyc - s, 1);
        chk("t5b_wen_dat", o_wen_dat, 8'd20);
        chk("t5b_dones", o_done, 1);
        if (o_tick_cyc.size() > 0) chk("t5b_tick_latency", o_tick_cyc[0] - s, 4);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ld;
            logic [7:0] tm;
            ld = 8'($urandom);
            tm = ld + 8'($urandom_range(0, 10));
            step(($urandom % 64) == 0, ($urandom % 4) == 0, 2'($urandom),
                 ld, tm, 4'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
